// File: rtl/nor_idle_monitor.sv
// ============================================================================
// Module   : nor_idle_monitor
// Purpose  : Qualifies the all-zero (NOR) request indication over time and
//            produces a registered idle level, entry/exit pulses, the current
//            zero-run length and a saturating wake-up event count.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nor_idle_monitor #(
  parameter int IDLE_CYCLES = 4,
  parameter int RUN_W       = 8,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             nor_in,
  input  logic             clr_count,
  output logic             idle,
  output logic             idle_rise,
  output logic             idle_fall,
  output logic [RUN_W-1:0] run_len,
  output logic [CNT_W-1:0] wake_count
);

  localparam logic [RUN_W-1:0] C_IDLE_THRESH = RUN_W'(IDLE_CYCLES);
  localparam logic [RUN_W-1:0] C_RUN_MAX     = {RUN_W{1'b1}};
  localparam logic [CNT_W-1:0] C_CNT_MAX     = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_COUNT  = 2'd1,
    ST_IDLE   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_idle;
  logic             r_rise;
  logic             r_fall;
  logic [RUN_W-1:0] r_run;
  logic [CNT_W-1:0] r_wake;

  logic             w_idle_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;
  logic [RUN_W-1:0] w_run_nxt;
  logic [CNT_W-1:0] w_wake_nxt;
  logic [RUN_W-1:0] w_run_inc;
  logic             w_wake_evt;

  assign w_run_inc = (r_run == C_RUN_MAX) ? r_run : r_run + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACTIVE;
      r_idle  <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_run   <= '0;
      r_wake  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idle  <= w_idle_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_run   <= w_run_nxt;
      r_wake  <= w_wake_nxt;
    end
  end

  // With en low everything holds and pulses drop; nor_in is not looked at,
  // so a gap in sampling never breaks a run in progress.
  always_comb begin
    w_state_nxt = r_state;
    w_idle_nxt  = r_idle;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    w_run_nxt   = r_run;
    w_wake_evt  = 1'b0;
    if (en) begin
      case (r_state)
        ST_ACTIVE: begin
          w_idle_nxt = 1'b0;
          if (nor_in) begin
            w_state_nxt = ST_COUNT;
            w_run_nxt   = {{(RUN_W-1){1'b0}}, 1'b1};
          end else begin
            w_run_nxt   = '0;
          end
        end
        ST_COUNT: begin
          w_idle_nxt = 1'b0;
          if (nor_in) begin
            w_run_nxt = w_run_inc;
            if (w_run_inc == C_IDLE_THRESH) begin
              w_state_nxt = ST_IDLE;
              w_idle_nxt  = 1'b1;
              w_rise_nxt  = 1'b1;
            end
          end else begin
            w_state_nxt = ST_ACTIVE;
            w_run_nxt   = '0;
          end
        end
        ST_IDLE: begin
          if (nor_in) begin
            w_idle_nxt = 1'b1;
            w_run_nxt  = w_run_inc;
          end else begin
            w_state_nxt = ST_ACTIVE;
            w_idle_nxt  = 1'b0;
            w_fall_nxt  = 1'b1;
            w_run_nxt   = '0;
            w_wake_evt  = 1'b1;
          end
        end
        default: begin
          w_state_nxt = ST_ACTIVE;
          w_idle_nxt  = 1'b0;
          w_run_nxt   = '0;
        end
      endcase
    end
  end

  // Clear has priority over a coincident wake event.
  always_comb begin
    w_wake_nxt = r_wake;
    if (clr_count) begin
      w_wake_nxt = '0;
    end else if (w_wake_evt && (r_wake != C_CNT_MAX)) begin
      w_wake_nxt = r_wake + 1'b1;
    end
  end

  assign idle       = r_idle;
  assign idle_rise  = r_rise;
  assign idle_fall  = r_fall;
  assign run_len    = r_run;
  assign wake_count = r_wake;

endmodule

`default_nettype wire

// File: tb/tb_nor_idle_monitor.sv
// ============================================================================
// Module   : tb_nor_idle_monitor
// Purpose  : Directed self-checking bench for nor_idle_monitor (two configs).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nor_idle_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_en, a_nor, a_clr;
  logic       a_idle, a_rise, a_fall;
  logic [7:0] a_run, a_wake;
  logic       b_en, b_nor, b_clr;
  logic       b_idle, b_rise, b_fall;
  logic [7:0] b_run;
  logic [1:0] b_wake;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nor_idle_monitor #(.IDLE_CYCLES(4), .RUN_W(8), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst), .en(a_en), .nor_in(a_nor), .clr_count(a_clr),
    .idle(a_idle), .idle_rise(a_rise), .idle_fall(a_fall),
    .run_len(a_run), .wake_count(a_wake)
  );

  nor_idle_monitor #(.IDLE_CYCLES(2), .RUN_W(8), .CNT_W(2)) u_dut_b (
    .clk(clk), .rst(rst), .en(b_en), .nor_in(b_nor), .clr_count(b_clr),
    .idle(b_idle), .idle_rise(b_rise), .idle_fall(b_fall),
    .run_len(b_run), .wake_count(b_wake)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks all of DUT A's outputs in one go.
  task automatic chk_a(input string tag, input int idl, input int rs,
                       input int fl, input int rl, input int wk);
    check({tag, ".idle"}, int'(a_idle), idl);
    check({tag, ".rise"}, int'(a_rise), rs);
    check({tag, ".fall"}, int'(a_fall), fl);
    check({tag, ".run"},  int'(a_run),  rl);
    check({tag, ".wake"}, int'(a_wake), wk);
  endtask

  initial begin
    int exp_wake [5] = '{1, 2, 3, 3, 3};
    rst = 1'b1;
    a_en = 1'b0; a_nor = 1'b0; a_clr = 1'b0;
    b_en = 1'b0; b_nor = 1'b0; b_clr = 1'b0;
    step(); step();
    chk_a("reset", 0, 0, 0, 0, 0);
    check("reset.b_wake", int'(b_wake), 0);

    // Basic entry
    rst = 1'b0; a_en = 1'b1; a_nor = 1'b1;
    step(); chk_a("entry1", 0, 0, 0, 1, 0);
    step(); chk_a("entry2", 0, 0, 0, 2, 0);
    step(); chk_a("entry3", 0, 0, 0, 3, 0);
    step(); chk_a("entry4", 1, 1, 0, 4, 0);
    step(); chk_a("entry5", 1, 0, 0, 5, 0);
    step(); chk_a("entry6", 1, 0, 0, 6, 0);

    // Exit
    a_nor = 1'b0;
    step(); chk_a("exit", 0, 0, 1, 0, 1);
    step(); chk_a("exit_post", 0, 0, 0, 0, 1);

    // Broken run 1,1,1,0,1,1,1,1
    a_nor = 1'b1; step(); step(); step();
    chk_a("brk3", 0, 0, 0, 3, 1);
    a_nor = 1'b0; step();
    chk_a("brk0", 0, 0, 0, 0, 1);
    a_nor = 1'b1; step(); step(); step();
    chk_a("brk7", 0, 0, 0, 3, 1);
    step();
    chk_a("brk8", 1, 1, 0, 4, 1);
    a_nor = 1'b0; step();
    chk_a("brk_exit", 0, 0, 1, 0, 2);

    // Enable hold: 2 samples, 5 disabled cycles with nor_in=0, 2 samples
    a_nor = 1'b1; step(); step();
    chk_a("hold_pre", 0, 0, 0, 2, 2);
    a_en = 1'b0; a_nor = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_a("hold_off", 0, 0, 0, 2, 2);
    end
    a_en = 1'b1; a_nor = 1'b1;
    step(); chk_a("hold_s3", 0, 0, 0, 3, 2);
    step(); chk_a("hold_s4", 1, 1, 0, 4, 2);

    // en=0 in IDLE with nor_in=0: no exit, no pulse
    a_en = 1'b0; a_nor = 1'b0;
    step(); chk_a("idle_hold", 1, 0, 0, 4, 2);
    a_en = 1'b1; a_nor = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk_a("run10", 1, 0, 0, 10, 2);

    // Reset mid-IDLE
    rst = 1'b1; step();
    chk_a("midrst", 0, 0, 0, 0, 0);
    rst = 1'b0; step(); step(); step();
    chk_a("reent3", 0, 0, 0, 3, 0);
    step();
    chk_a("reent4", 1, 1, 0, 4, 0);

    // clr_count with en=0
    a_nor = 1'b0; step();
    chk_a("pre_clr", 0, 0, 1, 0, 1);
    a_en = 1'b0; a_clr = 1'b1; step();
    chk_a("clr_en0", 0, 0, 0, 0, 0);
    a_clr = 1'b0; a_en = 1'b0;

    // Saturation on config B: IDLE_CYCLES=2, CNT_W=2
    b_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b_nor = 1'b1; step(); step();
      check("b_enter.idle", int'(b_idle), 1);
      check("b_enter.rise", int'(b_rise), 1);
      b_nor = 1'b0; step();
      check("b_exit.fall", int'(b_fall), 1);
      check("b_exit.wake", int'(b_wake), exp_wake[k]);
    end
    b_nor = 1'b1; step(); step();
    check("b_6th.idle", int'(b_idle), 1);
    b_nor = 1'b0; b_clr = 1'b1; step();
    check("b_clr.wake", int'(b_wake), 0);
    check("b_clr.fall", int'(b_fall), 1);
    check("b_clr.idle", int'(b_idle), 0);
    b_clr = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/nor_idle_monitor.md
Name: nor_idle_monitor

Overview:
Sequential consumer of the single-bit output of the 4-input NOR stage (nor4_nor2). A NOR output of 1 means all four request lines are 0. The block qualifies that signal over time. It asserts a registered idle level after IDLE_CYCLES consecutive sampled 1s, emits one-cycle entry/exit pulses, tracks the current zero-run length and counts wake-up events. It sits directly downstream of the NOR stage and feeds power/clock-gating control.

Parameters:
IDLE_CYCLES, 4, consecutive nor_in=1 samples needed to enter IDLE; legal range 2 to 2^RUN_W-1
RUN_W, 8, width of run_len (saturating)
CNT_W, 8, width of wake_count (saturating)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
en  input  1  sample enable; 0 = hold all state
nor_in  input  1  out of nor4_nor2; 1 = all inputs zero
clr_count  input  1  synchronous clear of wake_count
idle  output  1  registered idle level
idle_rise  output  1  one-cycle pulse on ACTIVE/COUNT->IDLE
idle_fall  output  1  one-cycle pulse on IDLE->ACTIVE
run_len  output  RUN_W  consecutive nor_in=1 samples in current run, saturating
wake_count  output  CNT_W  number of IDLE->ACTIVE exits, saturating

Behaviour:
- All outputs registered; no combinational path from inputs to outputs.
- Reset (rst=1 at edge, dominates all else): state=ACTIVE, idle=0, idle_rise=0, idle_fall=0, run_len=0, wake_count=0.
- States: ACTIVE, COUNT, IDLE. Encoding is free.
- ACTIVE: nor_in=1 -> COUNT, run_len=1. nor_in=0 -> stay, run_len=0.
- COUNT: nor_in=0 -> ACTIVE, run_len=0, no pulses.
- COUNT: nor_in=1 -> run_len+1. If the new run_len equals IDLE_CYCLES, go to IDLE, idle=1, idle_rise=1 for that one cycle.
- Latency: idle is high after the edge that samples the IDLE_CYCLES-th consecutive 1.
- IDLE: nor_in=1 -> stay, run_len increments, saturating at 2^RUN_W-1 (no wrap).
- IDLE: nor_in=0 -> ACTIVE, idle=0, idle_fall=1 for one cycle, run_len=0, wake_count+1 (saturates at 2^CNT_W-1).
- idle_rise and idle_fall are never both 1. Each is 0 on every cycle other than its transition cycle.
- en=0: state, idle, run_len and wake_count hold; idle_rise and idle_fall forced 0. nor_in is ignored, so a 0 during en=0 does not break a run.
- clr_count=1 (with en either value): wake_count=0 next cycle. If clr_count and a wake event coincide, clear wins (wake_count=0).
- rst asserted mid-COUNT or mid-IDLE: immediate return to reset values next edge; no idle_fall pulse is generated.
- nor_in is assumed synchronous to clk; no synchronizer inside.

Test Plan:
- Basic entry: rst 2 cycles, en=1, nor_in=1 held. run_len reads 1,2,3,4. idle=1 and idle_rise=1 exactly on the 4th sample's cycle. idle_rise=0 afterwards while run_len continues 5,6,...
- Exit: from IDLE drive nor_in=0 for one cycle. Next cycle idle=0, idle_fall=1 for one cycle, run_len=0, wake_count=1.
- Broken run: nor_in sequence 1,1,1,0,1,1,1,1 -> no idle after the first three 1s and run_len=0 after the 0. idle rises only on the 8th sample (run_len=4).
- Enable hold: nor_in=1 for 2 samples, then en=0 for 5 cycles with nor_in=0, then en=1, nor_in=1 for 2 samples. idle asserts with run_len=4 and no pulses during en=0.
- Saturation: CNT_W=2, IDLE_CYCLES=2. Perform 5 enter/exit cycles -> wake_count reads 1,2,3,3,3. Then clr_count=1 coincident with a 6th exit -> wake_count=0 and idle_fall=1.
- Reset mid-operation: in IDLE with run_len=10, pulse rst one cycle -> idle=0, run_len=0, wake_count=0, idle_fall=0. Re-entry requires a full 4 new samples.
